// File: rtl/muxn_seq.sv
// N-channel registered mux with manual select and timed auto-scan; optional break-before-make via MUXN_SEQ_BLANK_EN.
// Latency: out follows sel_cur by 1 cycle (2 on a switch when blanking is built in); enable=0 freezes all state.
module muxn_seq #(
    parameter int WIDTH = 1,
    parameter int NCH   = 4,
    parameter int DWELL = 20,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   in_bus,
    input  logic                   enable,
    input  logic                   mode,
    input  logic                   load,
    input  logic [SELW-1:0]        sel_in,
    output logic [WIDTH-1:0]       out,
    output logic [SELW-1:0]        sel_cur,
    output logic                   switch_pulse,
    output logic                   sel_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MANUAL,
        ST_AUTO
    } state_t;

    localparam logic [SELW:0]   NCH_W      = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] SEL_LAST   = SELW'(NCH - 1);
    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);

    state_t            state_d, state_q;
    logic [WIDTH-1:0]  out_d, out_q;
    logic [SELW-1:0]   sel_d, sel_q;
    logic [15:0]       dwell_d, dwell_q, dwell_eff;
    logic              pulse_d, pulse_q;
    logic              err_d, err_q;
    logic [WIDTH-1:0]  ch_dat;

    always_comb begin
        state_d   = ST_IDLE;
        out_d     = out_q;
        sel_d     = sel_q;
        dwell_d   = dwell_q;
        dwell_eff = dwell_q;
        err_d     = err_q;
        ch_dat    = '0;

        if (enable) begin
            state_d = mode ? ST_AUTO : ST_MANUAL;
        end

        for (int k = 0; k < NCH; k++) begin
            if (sel_q == SELW'(k)) begin
                ch_dat = in_bus[k*WIDTH +: WIDTH];
            end
        end

        case (state_d)
            ST_MANUAL: begin
                out_d = ch_dat;
                if (load) begin
                    if ({1'b0, sel_in} < NCH_W) begin
                        sel_d = sel_in;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_AUTO: begin
                out_d = ch_dat;
                // Coming straight from MANUAL restarts the dwell; from IDLE it resumes.
                if (state_q == ST_MANUAL) begin
                    dwell_eff = '0;
                end
                if (dwell_eff == DWELL_LAST) begin
                    sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_eff + 1'b1;
                end
            end
            default: ;
        endcase

        pulse_d = (sel_d != sel_q);

`ifdef MUXN_SEQ_BLANK_EN
        if (state_d != ST_IDLE && pulse_q) begin
            out_d = '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            sel_q   <= '0;
            dwell_q <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign out          = out_q;
    assign sel_cur      = sel_q;
    assign switch_pulse = pulse_q;
    assign sel_err      = err_q;

endmodule
